// File: rtl/div_iter_if.sv
// Request/response bundle for the iterative divider: start/ready handshake,
// operands in, registered result and done pulse out, plus squash.
interface div_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            squash;
    logic            start;
    logic [1:0]      func;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            ready;
    logic [XLEN-1:0] result;
    logic            done;

    modport master (
        output squash, start, func, dividend, divisor,
        input  ready, result, done
    );

    modport slave (
        input  squash, start, func, dividend, divisor,
        output ready, result, done
    );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU, BITS_PER_CYCLE quotient bits per cycle.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the CALC phase.
module div_iter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input logic         clock,
    input logic         reset,
    div_iter_if.slave   bus
);
    localparam int unsigned Steps = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);
    localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            ready_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;
    logic            sel_rem_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            div_zero_q;
    logic            ovf_q;
    logic [XLEN-1:0] dvd_raw_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;

    // Request decode, evaluated against the live operands at the accepting edge.
    logic            in_signed;
    logic            in_dz;
    logic            in_ovf;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;

    always_comb begin
        in_signed = ~bus.func[0];
        in_dz     = (bus.divisor == '0);
        in_ovf    = in_signed && (bus.dividend == MinVal) && (bus.divisor == '1);
        a_abs     = (in_signed && bus.dividend[XLEN-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
        b_abs     = (in_signed && bus.divisor[XLEN-1]) ? (~bus.divisor + 1'b1) : bus.divisor;
    end

    // Restoring steps; the shifted remainder needs XLEN+1 bits since it may reach 2*divisor-1.
    logic [XLEN:0]   sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    always_comb begin
        rem_nxt = rem_q;
        quo_nxt = quo_q;
        sh      = '0;
        diff    = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            sh   = {rem_nxt, quo_nxt[XLEN-1]};
            diff = sh - {1'b0, dvs_q};
            if (!diff[XLEN]) begin
                rem_nxt = diff[XLEN-1:0];
                quo_nxt = {quo_nxt[XLEN-2:0], 1'b1};
            end else begin
                rem_nxt = sh[XLEN-1:0];
                quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
            end
        end
    end

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        q_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        r_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        if (div_zero_q) begin
            q_fix = '1;
            r_fix = dvd_raw_q;
        end else if (ovf_q) begin
            q_fix = dvd_raw_q;
            r_fix = '0;
        end
        fix_result = sel_rem_q ? r_fix : q_fix;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
            sel_rem_q  <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            dvd_raw_q  <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
        end else if (bus.squash) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                    if (bus.start) begin
                        sel_rem_q  <= bus.func[1];
                        q_neg_q    <= in_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                        r_neg_q    <= in_signed && bus.dividend[XLEN-1];
                        div_zero_q <= in_dz;
                        ovf_q      <= in_ovf;
                        dvd_raw_q  <= bus.dividend;
                        dvs_q      <= b_abs;
                        rem_q      <= '0;
                        quo_q      <= a_abs;
                        cnt_q      <= '0;
                        ready_q    <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
                        state_q    <= (in_dz || in_ovf) ? StFixup : StCalc;
`else
                        state_q    <= StCalc;
`endif
                    end
                end
                StCalc: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt_q == LastCnt) begin
                        cnt_q   <= '0;
                        state_q <= StFixup;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFixup: begin
                    result_q <= fix_result;
                    done_q   <= 1'b1;
                    ready_q  <= 1'b1;
                    state_q  <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed RISC-V corner cases plus randomized
// back-to-back traffic against a 64-bit arithmetic reference model.
module tb_div_iter;
    localparam int unsigned XLEN = 32;
    localparam int unsigned Bpc  = 2;
    localparam int unsigned FullLat = XLEN / Bpc + 2;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_res = '0;

    div_iter_if #(.XLEN(XLEN)) bus ();

    div_iter #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (Bpc)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint na, nb, q, r;
        if (f[0]) begin
            na = longint'({32'b0, a});
            nb = longint'({32'b0, b});
        end else begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end
        if (b == 32'd0) begin
            q = -1;
            r = na;
        end else begin
            q = na / nb;
            r = na % nb;
        end
        return f[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_latency(input logic [1:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (EarlyOut && special) ? 2 : FullLat;
    endfunction

    // Caller is positioned at a negedge with ready expected high.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        int lat;
        logic [31:0] exp;
        lat = ref_latency(f, a, b);
        exp = ref_result(f, a, b);
        check({tag, ".rdy_at_start"}, {31'b0, bus.ready}, 32'd1);
        bus.start    = 1'b1;
        bus.func     = f;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clock);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            if (k < lat) begin
                check({tag, ".busy"}, {30'b0, bus.ready, bus.done}, 32'd0);
                bus.start = poke && (k == 3);
                if (poke && k == 3) begin
                    bus.dividend = 32'd1;
                    bus.divisor  = 32'd1;
                end
            end else begin
                check({tag, ".done"}, {31'b0, bus.done}, 32'd1);
                check({tag, ".rdy_done"}, {31'b0, bus.ready}, 32'd1);
                check({tag, ".result"}, bus.result, exp);
            end
        end
        last_res = exp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("idle.done", {31'b0, bus.done}, 32'd0);
            check("idle.hold", bus.result, last_res);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.squash   = 1'b0;
        bus.start    = 1'b0;
        bus.func     = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst.ready", {31'b0, bus.ready}, 32'd1);
        check("rst.done", {31'b0, bus.done}, 32'd0);
        check("rst.result", bus.result, 32'd0);

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0);
        idle(1);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("div_x_0", 2'b00, 32'h1234, 32'd0, 1'b0);
        run_op("divu_x_0", 2'b01, 32'h1234, 32'd0, 1'b0);
        run_op("remu_x_0", 2'b11, 32'h1234, 32'd0, 1'b0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(2);

        // Squash mid-flight; the simultaneous start must be dropped.
        bus.start = 1'b1; bus.func = 2'b01; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clock);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check("sq.busy", {30'b0, bus.ready, bus.done}, 32'd0);
        end
        bus.squash = 1'b1; bus.start = 1'b1; bus.dividend = 32'd1; bus.divisor = 32'd1;
        @(posedge clock);
        #1 begin bus.squash = 1'b0; bus.start = 1'b0; end
        @(negedge clock);
        check("sq.ready", {31'b0, bus.ready}, 32'd1);
        check("sq.nodone", {31'b0, bus.done}, 32'd0);
        check("sq.hold", bus.result, last_res);
        run_op("after_sq_9_3", 2'b01, 32'd9, 32'd3, 1'b0);

        // Back-to-back, with an ignored start while busy.
        run_op("b2b_1", 2'b01, 32'd100, 32'd7, 1'b1);
        run_op("b2b_2", 2'b01, 32'd50, 32'd5, 1'b1);
        idle(3);

        // Reset in the middle of an operation clears the result.
        bus.start = 1'b1; bus.func = 2'b00; bus.dividend = 32'd77; bus.divisor = 32'd5;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_res = '0;
        check("midrst.result", bus.result, 32'd0);
        check("midrst.ready", {31'b0, bus.ready}, 32'd1);
        idle(FullLat);

        for (int n = 0; n < 60; n++) begin
            logic [1:0]  f;
            logic [31:0] a, b;
            f = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op("rand", f, a, b, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
